impact_row_sequencer: RTL
=========================

# impact_row_sequencer

Command-driven access sequencer for one IMPACT SRAM bank, sitting directly upstream of the bank's word decoder and bitline pads. It accepts one read or write command at a time, then runs a fixed precharge, gap, word-line and recover sequence. During that sequence it drives the 10-bit row select into the decoder and the differential bitline drivers. It returns read data sampled from the bitlines with a one-cycle response strobe.

## Interface
- PRE_CYC, 2: precharge length in cycles, legal 1..15.
- WL_CYC, 4: word-line active length in cycles, legal 1..15.
- PARK_SEL, 10'h3E0: row-select value when no row is addressed. It must have a nonzero bit in [9:5], so the decoder asserts no word line.

- wb_clk_i, input, 1: single clock, all state on rising edge.
- wb_rst_n, input, 1: asynchronous, active-low reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block can accept a command.
- cmd_we, input, 1: 1 = write, 0 = read.
- cmd_row, input, 5: target word line 0..31.
- cmd_wdata, input, 16: write data.
- row_sel, output, 10: to word decoder sel[9:0].
- pre_en, output, 1: bitline precharge enable.
- bl_drv_en, output, 1: bitline driver enable (write only).
- bl_out, output, 16: true-bitline drive value.
- blb_out, output, 16: complement-bitline drive value.
- bl_in, input, 16: sensed true-bitline value.
- rsp_valid, output, 1: one-cycle completion strobe.
- rsp_rdata, output, 16: read data, held until the next read completes.

## Operation
- All outputs are registered.
- Reset values:
  - row_sel = PARK_SEL
  - cmd_ready = 1
  - pre_en = 0
  - bl_drv_en = 0
  - bl_out = 0
  - blb_out = 0
  - rsp_valid = 0
  - rsp_rdata = 0
- FSM states: IDLE, PRE, GAP, ACT, DONE.
- IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch we/row/wdata, go to PRE and load cnt = PRE_CYC-1.
- PRE: pre_en = 1, row_sel = PARK_SEL. When cnt reaches 0, go to GAP; otherwise decrement cnt.
- GAP: exactly one cycle with pre_en = 0 and row_sel = PARK_SEL (break-before-make). Load cnt = WL_CYC-1, go to ACT.
- ACT: row_sel = {5'b0, row}.
  - Write: bl_drv_en = 1, bl_out = wdata, blb_out = ~wdata.
  - Read: bl_drv_en = 0; bl_out and blb_out hold their previous values.
  - When cnt reaches 0, a read samples bl_in into rsp_rdata on that edge, and the FSM goes to DONE.
- DONE: row_sel = PARK_SEL, bl_drv_en = 0, rsp_valid = 1 for this cycle only. Go to IDLE.
- cmd_ready is 0 in every state except IDLE. cmd_valid while busy is ignored, not queued.
- rsp_rdata is unchanged by writes.
- cnt is 4 bits and counts down only; it never wraps, because it is reloaded before each count phase.
- Reset asserted mid-operation:
  - All outputs return to their reset values asynchronously.
  - The latched command is discarded and no rsp_valid is produced.
  - After deassertion the block is in IDLE.
- Mutual exclusion that must always hold:
  - pre_en and a decoded row (row_sel[9:5] == 0) are never active in the same cycle.
  - bl_drv_en is never high outside ACT.

## Timing
- Cycle 0 is the accept edge (cmd_valid && cmd_ready).
- PRE covers cycles 1..PRE_CYC.
- GAP is cycle PRE_CYC+1.
- ACT covers cycles PRE_CYC+2 .. PRE_CYC+WL_CYC+1.
- rsp_valid is high in cycle PRE_CYC+WL_CYC+2.
- cmd_ready rises in cycle PRE_CYC+WL_CYC+3, so the earliest next accept is at that edge.
- Default latency from accept to rsp_valid is 8 cycles; minimum command spacing is 9 cycles.
- Read data is the bl_in value present at the last ACT edge. bl_in must be stable during the final ACT cycle.

## Test plan
- Write row 5, wdata 16'hA5C3 (defaults) -> pre_en high in cycles 1-2; GAP in cycle 3; cycles 4-7 show row_sel = 10'd5, bl_drv_en = 1, bl_out = A5C3, blb_out = 5A3C; cycle 8 shows rsp_valid = 1 and row_sel = 10'h3E0.
- Read row 31 with bl_in = 16'h1234 held -> row_sel = 10'd31 in cycles 4-7, bl_drv_en = 0 throughout, rsp_rdata = 1234 with rsp_valid in cycle 8.
- cmd_valid held high for two back-to-back commands -> cmd_ready low in cycles 1-8, second command accepted at cycle 9, two rsp_valid pulses exactly 9 cycles apart.
- wb_rst_n pulsed low in cycle 5 of a write -> outputs go to reset values immediately, no rsp_valid, row_sel = 3E0, and a new command is accepted after release.
- PRE_CYC = 1, WL_CYC = 1 -> read latency to rsp_valid is 4 cycles; pre_en and a decoded row_sel never coincide.
- Idle with random cmd_row/cmd_wdata and cmd_valid = 0 for 50 cycles -> row_sel stays 3E0; pre_en, bl_drv_en and rsp_valid stay 0.

Source files
------------

// File: rtl/impact_row_sequencer_if.sv
// Command/response channel between a bank controller and impact_row_sequencer.
// The master issues one command at a time; the slave answers with a one-cycle strobe.
interface impact_row_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [4:0]  cmd_row;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;

    modport master (
        output cmd_valid,
        output cmd_we,
        output cmd_row,
        output cmd_wdata,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  cmd_valid,
        input  cmd_we,
        input  cmd_row,
        input  cmd_wdata,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata
    );
endinterface

// File: rtl/impact_row_sequencer.sv
// Single-bank IMPACT SRAM access sequencer: precharge, break-before-make gap,
// word-line pulse and recover, with all decoder/bitline outputs registered.
module impact_row_sequencer #(
    parameter int unsigned PRE_CYC  = 2,
    parameter int unsigned WL_CYC   = 4,
    parameter logic [9:0]  PARK_SEL = 10'h3E0
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n,
    impact_row_sequencer_if.slave        cmd,
    output logic [9:0]                   row_sel,
    output logic                         pre_en,
    output logic                         bl_drv_en,
    output logic [15:0]                  bl_out,
    output logic [15:0]                  blb_out,
    input  logic [15:0]                  bl_in
);

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
    localparam logic [3:0] WL_LOAD  = 4'(WL_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        GAP,
        ACT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [4:0]  lat_row;
    logic [15:0] lat_wdata;

    // NOTE: every register here is assigned with <= so all branches see the
    // pre-edge values; a blocking assignment would leak new state into later reads.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            // NOTE: the command latch is plain flops, not a memory, so it is
            // reset too; a discarded command can never resurface after reset.
            lat_we        <= 1'b0;
            lat_row       <= '0;
            lat_wdata     <= '0;
            row_sel       <= PARK_SEL;
            pre_en        <= 1'b0;
            bl_drv_en     <= 1'b0;
            bl_out        <= '0;
            blb_out       <= '0;
            cmd.cmd_ready <= 1'b1;
            cmd.rsp_valid <= 1'b0;
            cmd.rsp_rdata <= '0;
        end else begin
            cmd.rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        lat_we        <= cmd.cmd_we;
                        lat_row       <= cmd.cmd_row;
                        lat_wdata     <= cmd.cmd_wdata;
                        cnt           <= PRE_LOAD;
                        cmd.cmd_ready <= 1'b0;
                        pre_en        <= 1'b1;
                        row_sel       <= PARK_SEL;
                        state         <= PRE;
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        pre_en <= 1'b0;
                        state  <= GAP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP: begin
                    // Row only decodes after a full cycle with precharge released.
                    cnt     <= WL_LOAD;
                    row_sel <= {5'b0, lat_row};
                    if (lat_we) begin
                        bl_drv_en <= 1'b1;
                        bl_out    <= lat_wdata;
                        blb_out   <= ~lat_wdata;
                    end else begin
                        bl_drv_en <= 1'b0;
                    end
                    state <= ACT;
                end
                ACT: begin
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            cmd.rsp_rdata <= bl_in;
                        end
                        row_sel       <= PARK_SEL;
                        bl_drv_en     <= 1'b0;
                        cmd.rsp_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    cmd.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    row_sel       <= PARK_SEL;
                    pre_en        <= 1'b0;
                    bl_drv_en     <= 1'b0;
                    cmd.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
